program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Boot-time instruction loader that sits directly upstream of the fetch stage. It receives a program as a byte stream from the UART receiver and assembles little-endian 32-bit words. It writes those words into the instruction ROM write port and holds the CPU in reset until the image is loaded and the checksum verifies. It then reports the result over the UART transmitter and releases the CPU.

Parameters:
ROM_ADDRESS_BITWIDTH, 12, width of ROM write address; byte address, word-aligned; MAX_WORDS = 2^(ROM_ADDRESS_BITWIDTH-2)
ACK_OK, 8'hAA, byte sent on successful load
ACK_ERR, 8'h55, byte sent on any load failure

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle
tx_data  output  8  status byte to UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts tx_data
rom_wren  output  1  ROM write strobe, one cycle per word
rom_waddr  output  ROM_ADDRESS_BITWIDTH  ROM byte address (word_index*4)
rom_wdata  output  32  instruction word
cpu_reset_n  output  1  active-low CPU reset; 0 until load succeeds
load_done  output  1  high in RUN
load_error  output  1  high in ERROR

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - state=HEADER.
  - rom_wren=0, rom_waddr=0, rom_wdata=0.
  - tx_valid=0, tx_data=0.
  - cpu_reset_n=0, load_done=0, load_error=0.
  - Byte counter, word counter, word count N and checksum all cleared.
- Byte acceptance: a byte is accepted when rx_valid & rx_ready. rx_ready is combinational and equals 1 in HEADER, LOAD and CHECK, 0 in all other states.
- Byte lane: a 2-bit byte index k places the byte at bits [8k+7:8k]. The index wraps 3->0 on the 4th byte.
- HEADER state:
  - Collects 4 bytes forming the little-endian word count N (32 bit).
  - On the 4th byte: if N > MAX_WORDS go to ERROR. If N == 0 go to CHECK. Otherwise go to LOAD.
- LOAD state:
  - Every accepted byte is XORed into the 8-bit checksum.
  - On the 4th byte of each word, the next cycle drives rom_wren=1 for exactly one cycle, with rom_wdata = the assembled word and rom_waddr = word_index<<2.
  - word_index increments after each write.
  - After word N is written, go to CHECK. A new byte may be accepted in the same cycle as the write strobe.
- CHECK state:
  - Accepts one byte. If it equals the checksum go to ACK with tx_data=ACK_OK; otherwise go to ERROR.
  - The checksum of an empty payload is 0x00.
- ACK state:
  - tx_valid=1 with tx_data held stable until tx_ready. On the handshake, tx_valid drops the next cycle and the state goes to RUN.
- RUN state:
  - Terminal until reset. cpu_reset_n=1, load_done=1. No further ROM writes.
- ERROR state:
  - load_error=1 and cpu_reset_n stays 0.
  - Sends ACK_ERR once using the same tx handshake, then stays in ERROR until reset.
- Mid-operation and edge behaviour:
  - rx_valid while rx_ready=0 is ignored; the byte is not consumed.
  - Asserting reset at any point aborts immediately to the reset state. ROM contents already written are not cleared.
  - The address never wraps; the MAX_WORDS check guarantees this.

Decomposition:
- Shared defines file: state encodings (HEADER, LOAD, CHECK, ACK, RUN, ERROR) as 3-bit localparam-style macros, plus the ACK_OK and ACK_ERR codes.
- One natural sub-module: word_assembler (byte-lane shift, 2-bit index, word-complete pulse). It is reused by the header and payload paths.

Test Plan:
1. Normal load:
   - Stimulus: bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | 90.
   - Expected: writes (0x000, 0x00000013) and (0x004, 0x00100093), each strobe 1 cycle; tx 0xAA; then cpu_reset_n=1, load_done=1.
2. Empty image:
   - Stimulus: 00 00 00 00 then 00.
   - Expected: no rom_wren; tx 0xAA; RUN.
3. Oversize:
   - Stimulus: 01 04 00 00 (N=1025 > 1024).
   - Expected: ERROR immediately; tx 0x55; rx_ready=0; cpu_reset_n stays 0.
4. Bad checksum:
   - Stimulus: as test 1 but final byte 0x91.
   - Expected: both words are still written; tx 0x55; load_error=1; cpu_reset_n=0.
5. Backpressure:
   - Stimulus: hold tx_ready=0 for 10 cycles after the final byte.
   - Expected: tx_valid=1 and tx_data=0xAA stable throughout; RUN entered 1 cycle after tx_ready rises.
6. Reset mid-load:
   - Stimulus: assert reset after 6 payload bytes, then replay test 1.
   - Expected: outputs return to reset values asynchronously; the replay writes address 0 first and completes normally.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loader_state_e : FSM state encoding (3 bits)
//   ACK_OK/ACK_ERR : status bytes reported over the UART transmitter
package program_loader_pkg;

  typedef enum logic [2:0] {
    StHeader = 3'd0,
    StLoad   = 3'd1,
    StCheck  = 3'd2,
    StAck    = 3'd3,
    StRun    = 3'd4,
    StError  = 3'd5
  } loader_state_e;

  localparam logic [7:0] ACK_OK  = 8'hAA;
  localparam logic [7:0] ACK_ERR = 8'h55;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler shared by the header and payload paths.
//   clk, reset   : clock, asynchronous active-high reset
//   byte_valid_i : a byte is accepted this cycle
//   byte_i       : accepted byte
//   word_o       : assembled word including the byte accepted this cycle
//   word_done_o  : pulse when the accepted byte completes a word (lane 3)
module program_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  // Merge the incoming byte so the caller sees the complete word in the same cycle.
  always_comb begin
    word_o = word_q;
    word_o[{idx_q, 3'b000} +: 8] = byte_i;
  end

  assign word_done_o = byte_valid_i && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (byte_valid_i) begin
      word_q <= word_o;
      idx_q  <= idx_q + 2'd1;  // wraps 3 -> 0
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction loader. Receives a word count and program image as a
// byte stream, writes words into the instruction ROM, verifies an XOR checksum,
// reports ACK_OK/ACK_ERR over the UART transmitter and releases the CPU.
//   clk, reset                  : clock, asynchronous active-high reset
//   rx_data/rx_valid/rx_ready   : byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready   : status byte to the UART transmitter
//   rom_wren/rom_waddr/rom_wdata: ROM write port (byte address, word aligned)
//   cpu_reset_n                 : active-low CPU reset, released after a good load
//   load_done/load_error        : high in RUN / ERROR
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ROM_ADDRESS_BITWIDTH = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic                            rx_ready,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            rom_wren,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_waddr,
  output logic [31:0]                     rom_wdata,
  output logic                            cpu_reset_n,
  output logic                            load_done,
  output logic                            load_error
);

  localparam int unsigned MaxWords = 1 << (ROM_ADDRESS_BITWIDTH - 2);

  loader_state_e                   state_q;
  logic                            rom_wren_q;
  logic [ROM_ADDRESS_BITWIDTH-1:0] rom_waddr_q;
  logic [31:0]                     rom_wdata_q;
  logic                            tx_valid_q;
  logic [7:0]                      tx_data_q;
  logic                            cpu_reset_n_q;
  logic                            load_done_q;
  logic                            load_error_q;
  logic [31:0]                     word_cnt_q;
  logic [31:0]                     word_idx_q;
  logic [7:0]                      csum_q;

  logic        accept;
  logic [31:0] asm_word;
  logic        asm_done;

  assign rx_ready = (state_q == StHeader) || (state_q == StLoad) || (state_q == StCheck);
  assign accept   = rx_valid && rx_ready;

  // The CHECK byte also passes through the assembler; its lane index is
  // irrelevant afterwards because the loader never accepts another byte.
  program_loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .byte_valid_i (accept),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_done_o  (asm_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StHeader;
      rom_wren_q    <= 1'b0;
      rom_waddr_q   <= '0;
      rom_wdata_q   <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      cpu_reset_n_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
      word_cnt_q    <= '0;
      word_idx_q    <= '0;
      csum_q        <= '0;
    end else begin
      rom_wren_q <= 1'b0;
      unique case (state_q)
        StHeader: begin
          if (asm_done) begin
            word_cnt_q <= asm_word;
            if (asm_word > 32'(MaxWords)) begin
              state_q      <= StError;
              load_error_q <= 1'b1;
              tx_valid_q   <= 1'b1;
              tx_data_q    <= ACK_ERR;
            end else if (asm_word == 32'd0) begin
              state_q <= StCheck;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (accept) csum_q <= csum_q ^ rx_data;
          if (asm_done) begin
            rom_wren_q  <= 1'b1;
            rom_wdata_q <= asm_word;
            rom_waddr_q <= {word_idx_q[ROM_ADDRESS_BITWIDTH-3:0], 2'b00};
            word_idx_q  <= word_idx_q + 32'd1;
            if (word_idx_q + 32'd1 == word_cnt_q) state_q <= StCheck;
          end
        end
        StCheck: begin
          if (accept) begin
            tx_valid_q <= 1'b1;
            if (rx_data == csum_q) begin
              state_q   <= StAck;
              tx_data_q <= ACK_OK;
            end else begin
              state_q      <= StError;
              load_error_q <= 1'b1;
              tx_data_q    <= ACK_ERR;
            end
          end
        end
        StAck: begin
          if (tx_ready) begin
            tx_valid_q    <= 1'b0;
            state_q       <= StRun;
            cpu_reset_n_q <= 1'b1;
            load_done_q   <= 1'b1;
          end
        end
        StRun: begin
          // Terminal until reset.
        end
        StError: begin
          // tx_valid is only raised on entry, so ACK_ERR goes out exactly once.
          if (tx_valid_q && tx_ready) tx_valid_q <= 1'b0;
        end
        default: state_q <= StError;
      endcase
    end
  end

  assign rom_wren    = rom_wren_q;
  assign rom_waddr   = rom_waddr_q;
  assign rom_wdata   = rom_wdata_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        rom_wren;
  logic [11:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stim_q[$];
  logic [11:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_log_q[$];

  program_loader #(.ROM_ADDRESS_BITWIDTH(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rom_wren    (rom_wren),
    .rom_waddr   (rom_waddr),
    .rom_wdata   (rom_wdata),
    .cpu_reset_n (cpu_reset_n),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees stable handshakes.
  // Every high sample of rom_wren is logged: a strobe wider than one cycle
  // shows up as an extra entry.
  always @(negedge clk) begin
    if (rom_wren) begin
      wr_addr_q.push_back(rom_waddr);
      wr_data_q.push_back(rom_wdata);
    end
    if (tx_valid && tx_ready) tx_log_q.push_back(tx_data);
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_log_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rx_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte timeout: byte %h never accepted", b);
    end
  endtask

  task automatic send_stim();
    foreach (stim_q[i]) send_byte(stim_q[i]);
  endtask

  task automatic load_normal(input logic [7:0] last);
    stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, last};
  endtask

  task automatic wait_tx(input string name);
    int i = 0;
    while (tx_log_q.size() == 0 && i < 40) begin
      @(posedge clk); #1;
      i++;
    end
    n_checks++;
    if (tx_log_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s tx timeout: no tx handshake, required one", name);
    end
  endtask

  task automatic check_two_writes(input string name);
    n_checks++;
    if (wr_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL %s write count: got %0d required 2", name, wr_addr_q.size());
    end else begin
      n_checks++;
      if (wr_addr_q[0] !== 12'h000 || wr_data_q[0] !== 32'h0000_0013) begin
        n_fail++;
        $display("FAIL %s write0: got %h/%h required 000/00000013", name, wr_addr_q[0],
                 wr_data_q[0]);
      end
      n_checks++;
      if (wr_addr_q[1] !== 12'h004 || wr_data_q[1] !== 32'h0010_0093) begin
        n_fail++;
        $display("FAIL %s write1: got %h/%h required 004/00100093", name, wr_addr_q[1],
                 wr_data_q[1]);
      end
    end
  endtask

  task automatic check_tx(input string name, input logic [7:0] exp);
    n_checks++;
    if (tx_log_q.size() != 1 || tx_log_q[0] !== exp) begin
      n_fail++;
      $display("FAIL %s tx byte: got %0d bytes first %h required one byte %h", name,
               tx_log_q.size(), (tx_log_q.size() > 0) ? tx_log_q[0] : 8'hxx, exp);
    end
  endtask

  task automatic check_status(input string name, input logic crn, input logic done,
                              input logic err);
    n_checks++;
    if (cpu_reset_n !== crn || load_done !== done || load_error !== err) begin
      n_fail++;
      $display("FAIL %s status: got crn/done/err %b%b%b required %b%b%b", name, cpu_reset_n,
               load_done, load_error, crn, done, err);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (rom_wren !== 1'b0 || rom_waddr !== 12'h0 || rom_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL %s rom port: got %b %h %h required 0 000 00000000", name, rom_wren,
               rom_waddr, rom_wdata);
    end
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL %s tx port: got %b %h required 0 00", name, tx_valid, tx_data);
    end
    check_status(name, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rx_ready: got %b required 1", name, rx_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_normal_load();
    do_reset();
    load_normal(8'h90);
    send_stim();
    wait_tx("normal");
    repeat (3) @(posedge clk); #1;
    check_two_writes("normal");
    check_tx("normal", 8'hAA);
    check_status("normal", 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL normal run idle: got rx_ready %b tx_valid %b required 0 0", rx_ready,
               tx_valid);
    end
  endtask

  task automatic test_empty();
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stim();
    wait_tx("empty");
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (wr_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL empty writes: got %0d required 0", wr_addr_q.size());
    end
    check_tx("empty", 8'hAA);
    check_status("empty", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_oversize();
    do_reset();
    stim_q = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_stim();
    // Now one cycle past the 4th header byte.
    n_checks++;
    if (load_error !== 1'b1 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize entry: got load_error %b rx_ready %b required 1 0", load_error,
               rx_ready);
    end
    wait_tx("oversize");
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    repeat (10) @(posedge clk); #1;
    rx_valid = 1'b0;
    check_tx("oversize", 8'h55);
    check_status("oversize", 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b0 || wr_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL oversize idle: got tx_valid %b rx_ready %b writes %0d required 0 0 0",
               tx_valid, rx_ready, wr_addr_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    load_normal(8'h91);
    send_stim();
    wait_tx("badsum");
    repeat (5) @(posedge clk); #1;
    check_two_writes("badsum");
    check_tx("badsum", 8'h55);
    check_status("badsum", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    tx_ready = 1'b0;
    load_normal(8'h90);
    send_stim();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hAA || load_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure hold: %0d bad cycles of 10, required 0", bad);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (load_done !== 1'b1 || cpu_reset_n !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure release: got done %b crn %b tx_valid %b required 1 1 0",
               load_done, cpu_reset_n, tx_valid);
    end
    check_tx("backpressure", 8'hAA);
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_stim();
    n_checks++;
    if (wr_addr_q.size() != 1 || rom_wdata !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL midreset pre: got writes %0d wdata %h required 1 00000013",
               wr_addr_q.size(), rom_wdata);
    end
    #2 reset = 1'b1;  // mid-cycle: must act without a clock edge
    #1;
    check_reset_outputs("midreset async");
    @(posedge clk); #1;
    reset = 1'b0;
    clear_logs();
    load_normal(8'h90);
    send_stim();
    wait_tx("midreset replay");
    repeat (3) @(posedge clk); #1;
    check_two_writes("midreset replay");
    check_tx("midreset replay", 8'hAA);
    check_status("midreset replay", 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_empty();
    test_oversize();
    test_bad_checksum();
    test_backpressure();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
